ela_deinterlacer: RTL and testbench

Parametrised successor to the fixed 400x300 grey ELA processor. Reads a progressive-stored field image from a 1-cycle-latency read RAM, writes a deinterlaced frame to the processing memory: even rows copied, odd rows rebuilt by a selectable mode (copy, ELA, line repeat, vertical average). Supports arbitrary image size, per-channel width and channel count, and uses a start/done handshake in place of the free-running power-up counter.

---
 rtl/ela_deinterlacer_pkg.sv | 70 +++++++
 rtl/ela_deinterlacer_if.sv | 32 +++
 rtl/ela_deinterlacer_kernel.sv | 79 +++++++
 rtl/ela_deinterlacer.sv | 224 ++++++++++++++++++++++
 tb/tb_ela_deinterlacer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ela_deinterlacer_pkg.sv
// Shared types and helpers for the ELA deinterlacer.
// Holds the mode and state enums, tap indices, the read-list order, and
// per-channel avg/absdiff helpers. The helpers work on a PIX_MAX-wide
// container. Callers zero-extend PIX_W-bit channels into it, so the
// (PIX_MAX+1)-bit sum also covers the PIX_W+1-bit intermediate.
package ela_pkg;

  typedef enum logic [1:0] {
    MODE_COPY   = 2'd0,
    MODE_ELA    = 2'd1,
    MODE_REPEAT = 2'd2,
    MODE_VAVG   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COPY   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_GATHER = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int unsigned NUM_TAPS = 6;
  localparam int unsigned TAP_W    = 3;
  typedef logic [TAP_W-1:0] tap_t;

  // a/b/c: row above, cols x-1/x/x+1; d/e/f: row below, cols x-1/x/x+1
  localparam tap_t TAP_A = 3'd0;
  localparam tap_t TAP_B = 3'd1;
  localparam tap_t TAP_C = 3'd2;
  localparam tap_t TAP_D = 3'd3;
  localparam tap_t TAP_E = 3'd4;
  localparam tap_t TAP_F = 3'd5;

  localparam int unsigned PIX_MAX = 16;
  typedef logic [PIX_MAX-1:0] pix_t;

  // Floor average of two channels.
  function automatic pix_t pix_avg(input pix_t p, input pix_t q);
    logic [PIX_MAX:0] s;
    s = {1'b0, p} + {1'b0, q};
    return s[PIX_MAX:1];
  endfunction

  // Absolute difference of two channels.
  function automatic pix_t pix_absdiff(input pix_t p, input pix_t q);
    return (p > q) ? (p - q) : (q - p);
  endfunction

  // Tap fetched at step k of an n-read list: 6 -> a,f,b,e,c,d; 2 -> b,e; 1 -> b.
  function automatic tap_t seq_tap(input logic [2:0] n, input logic [2:0] k);
    tap_t t;
    t = TAP_B;
    if (n == 3'd6) begin
      case (k)
        3'd0:    t = TAP_A;
        3'd1:    t = TAP_F;
        3'd2:    t = TAP_B;
        3'd3:    t = TAP_E;
        3'd4:    t = TAP_C;
        default: t = TAP_D;
      endcase
    end else if (n == 3'd2 && k == 3'd1) begin
      t = TAP_E;
    end
    return t;
  endfunction

endpackage

// File: rtl/ela_deinterlacer_if.sv
// Control, read-port and write-port bundle of the ELA deinterlacer.
// slave: the deinterlacer (drives addresses, write data and status).
// master: the environment (drives start/cmd and the read data).
//   start, cmd         : job request and mode
//   r_addr, rd_data    : 1-cycle-latency read port
//   o_addr, data_out,
//   output_valid       : write port, one strobe per pixel
//   busy, done         : job status
interface ela_deinterlacer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
);
  logic              start;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] data_out;
  logic              output_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, cmd, rd_data,
    input  r_addr, o_addr, data_out, output_valid, busy, done
  );

  modport slave (
    input  start, cmd, rd_data,
    output r_addr, o_addr, data_out, output_valid, busy, done
  );
endinterface

// File: rtl/ela_deinterlacer_kernel.sv
// ela_kernel: combinational per-channel averages, summed absolute
// differences and ELA direction choice from six captured taps.
//   taps     : captured words indexed by TAP_A..TAP_F
//   ela_pix  : ELA result
//   vavg_pix : avg(b,e), the vertical average
// Optional feature macro: ELA_FALLBACK_EN. When it is defined, ELA falls
// back to avg(b,e) if even the best direction differs by more than
// FALLBACK_TH.
module ela_kernel
  import ela_pkg::*;
#(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned CH    = 3
`ifdef ELA_FALLBACK_EN
  ,
  parameter int unsigned FALLBACK_TH = 8
`endif
) (
  input  logic [NUM_TAPS-1:0][PIX_W*CH-1:0] taps,
  output logic [PIX_W*CH-1:0]               ela_pix,
  output logic [PIX_W*CH-1:0]               vavg_pix
);

  localparam int unsigned DATA_W = PIX_W * CH;
  localparam int unsigned DIFF_W = PIX_W + $clog2(CH) + 1;

  logic [DIFF_W-1:0] d1, d2, d3;
  logic [DATA_W-1:0] avg_af, avg_be, avg_cd, dir_pix;

  // Per-channel averages and channel-summed differences of the three pairs
  always_comb begin
    d1     = '0;
    d2     = '0;
    d3     = '0;
    avg_af = '0;
    avg_be = '0;
    avg_cd = '0;
    for (int c = 0; c < int'(CH); c++) begin
      d1 = d1 + DIFF_W'(pix_absdiff(PIX_MAX'(taps[TAP_A][c*PIX_W +: PIX_W]),
                                    PIX_MAX'(taps[TAP_F][c*PIX_W +: PIX_W])));
      d2 = d2 + DIFF_W'(pix_absdiff(PIX_MAX'(taps[TAP_B][c*PIX_W +: PIX_W]),
                                    PIX_MAX'(taps[TAP_E][c*PIX_W +: PIX_W])));
      d3 = d3 + DIFF_W'(pix_absdiff(PIX_MAX'(taps[TAP_C][c*PIX_W +: PIX_W]),
                                    PIX_MAX'(taps[TAP_D][c*PIX_W +: PIX_W])));
      avg_af[c*PIX_W +: PIX_W] = PIX_W'(pix_avg(PIX_MAX'(taps[TAP_A][c*PIX_W +: PIX_W]),
                                                PIX_MAX'(taps[TAP_F][c*PIX_W +: PIX_W])));
      avg_be[c*PIX_W +: PIX_W] = PIX_W'(pix_avg(PIX_MAX'(taps[TAP_B][c*PIX_W +: PIX_W]),
                                                PIX_MAX'(taps[TAP_E][c*PIX_W +: PIX_W])));
      avg_cd[c*PIX_W +: PIX_W] = PIX_W'(pix_avg(PIX_MAX'(taps[TAP_C][c*PIX_W +: PIX_W]),
                                                PIX_MAX'(taps[TAP_D][c*PIX_W +: PIX_W])));
    end
  end

  // Vertical wins ties, then the a-f diagonal over the c-d diagonal
  always_comb begin
    dir_pix = avg_cd;
    if (d2 <= d1 && d2 <= d3) begin
      dir_pix = avg_be;
    end else if (d1 <= d3) begin
      dir_pix = avg_af;
    end
  end

`ifdef ELA_FALLBACK_EN
  logic [DIFF_W-1:0] dmin;

  always_comb begin
    dmin = d1;
    if (d2 < dmin) dmin = d2;
    if (d3 < dmin) dmin = d3;
    ela_pix = (dmin > DIFF_W'(FALLBACK_TH)) ? avg_be : dir_pix;
  end
`else
  assign ela_pix = dir_pix;
`endif

  assign vavg_pix = avg_be;

endmodule

// File: rtl/ela_deinterlacer.sv
// ela_deinterlacer: copies a stored field image to the output memory, then
// rebuilds the odd rows in the mode chosen by cmd (copy, ELA, line repeat,
// vertical average).
//   clk_p, rst : clock and synchronous active-high reset
//   bus        : ela_deinterlacer_if.slave; start/cmd, the 1-cycle-latency
//                read port, the write port, and busy/done
// Optional feature macro: ELA_FALLBACK_EN (see ela_kernel).
module ela_deinterlacer
  import ela_pkg::*;
#(
  parameter int unsigned IMG_W       = 400,
  parameter int unsigned IMG_H       = 300,
  parameter int unsigned PIX_W       = 4,
  parameter int unsigned CH          = 3,
  parameter int unsigned FALLBACK_TH = 8
) (
  input logic               clk_p,
  input logic               rst,
  ela_deinterlacer_if.slave bus
);

  localparam int unsigned DATA_W = PIX_W * CH;
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int unsigned DIFF_W = PIX_W + $clog2(CH) + 1;
  localparam int unsigned XW     = $clog2(IMG_W);
  localparam int unsigned YW     = $clog2(IMG_H + 2);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);

  // Reject parameter sets the datapath cannot represent
  if (IMG_W < 3 || IMG_H < 2 || PIX_W > PIX_MAX || PIX_W == 0 || CH == 0 ||
      FALLBACK_TH >= (1 << DIFF_W)) begin : g_bad_cfg
    $error("ela_deinterlacer: unsupported parameter set");
  end

  state_e            state;
  mode_e             mode;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] r_addr_q, o_addr_q, req_addr;
  logic [DATA_W-1:0] data_out_q;
  logic              output_valid_q, busy_q, done_q;
  logic              copy_issue, rd_req;
  logic [2:0]        n_reads, gidx;
  tap_t              last_tap;

  logic [NUM_TAPS-1:0][DATA_W-1:0] taps_q, taps_c;
  logic [DATA_W-1:0]               ela_pix, vavg_pix, result_c;
  logic [2:0]                      n_sel_c;

  // Address of a neighbour tap relative to the pixel at p = y*W + x
  function automatic logic [ADDR_W-1:0] tap_addr(input tap_t t, input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] up, dn, a;
    up = p - ADDR_W'(IMG_W);
    dn = p + ADDR_W'(IMG_W);
    case (t)
      TAP_A:   a = up - ADDR_W'(1);
      TAP_B:   a = up;
      TAP_C:   a = up + ADDR_W'(1);
      TAP_D:   a = dn - ADDR_W'(1);
      TAP_E:   a = dn;
      default: a = dn + ADDR_W'(1);
    endcase
    return a;
  endfunction

  // Read-list length for the pixel at (x,y)
  always_comb begin
    n_sel_c = 3'd2;
    if (y == Y_LAST || mode == MODE_REPEAT) begin
      n_sel_c = 3'd1;
    end else if (mode == MODE_ELA && x != '0 && x != X_LAST) begin
      n_sel_c = 3'd6;
    end
  end

  // The last read lands in the WRITE cycle; bypass it into the kernel
  always_comb begin
    taps_c           = taps_q;
    taps_c[last_tap] = bus.rd_data;
    if (n_reads == 3'd1) begin
      result_c = taps_c[TAP_B];
    end else if (n_reads == 3'd6) begin
      result_c = ela_pix;
    end else begin
      result_c = vavg_pix;
    end
  end

  ela_kernel #(
    .PIX_W(PIX_W),
    .CH   (CH)
`ifdef ELA_FALLBACK_EN
    ,
    .FALLBACK_TH(FALLBACK_TH)
`endif
  ) u_kernel (
    .taps    (taps_c),
    .ela_pix (ela_pix),
    .vavg_pix(vavg_pix)
  );

  // Control FSM, addressing and registered outputs
  always_ff @(posedge clk_p) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode           <= MODE_COPY;
      x              <= '0;
      y              <= '0;
      pix_addr       <= '0;
      r_addr_q       <= '0;
      o_addr_q       <= '0;
      req_addr       <= '0;
      data_out_q     <= '0;
      output_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      copy_issue     <= 1'b0;
      rd_req         <= 1'b0;
      n_reads        <= 3'd1;
      gidx           <= '0;
      last_tap       <= TAP_B;
      taps_q         <= '0;
    end else begin
      output_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode       <= mode_e'(bus.cmd);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            r_addr_q   <= '0;
            copy_issue <= 1'b1;
            rd_req     <= 1'b0;
            state      <= ST_COPY;
          end
        end

        ST_COPY: begin
          // Issue side: one read per cycle until the last address
          if (copy_issue) begin
            rd_req   <= 1'b1;
            req_addr <= r_addr_q;
            if (r_addr_q == ADDR_LAST) copy_issue <= 1'b0;
            else                       r_addr_q   <= r_addr_q + ADDR_W'(1);
          end else begin
            rd_req <= 1'b0;
          end
          // Write side: data of last cycle's read goes straight out
          if (rd_req) begin
            output_valid_q <= 1'b1;
            o_addr_q       <= req_addr;
            data_out_q     <= bus.rd_data;
            if (req_addr == ADDR_LAST) begin
              if (mode == MODE_COPY) begin
                state <= ST_DONE;
              end else begin
                x        <= '0;
                y        <= YW'(1);
                pix_addr <= ADDR_W'(IMG_W);
                state    <= ST_CHECK;
              end
            end
          end
        end

        ST_CHECK: begin
          n_reads  <= n_sel_c;
          gidx     <= '0;
          r_addr_q <= tap_addr(seq_tap(n_sel_c, 3'd0), pix_addr);
          state    <= ST_GATHER;
        end

        ST_GATHER: begin
          if (gidx != '0) begin
            taps_q[seq_tap(n_reads, gidx - 3'd1)] <= bus.rd_data;
          end
          if (gidx == n_reads - 3'd1) begin
            last_tap <= seq_tap(n_reads, gidx);
            state    <= ST_WRITE;
          end else begin
            gidx     <= gidx + 3'd1;
            r_addr_q <= tap_addr(seq_tap(n_reads, gidx + 3'd1), pix_addr);
          end
        end

        ST_WRITE: begin
          output_valid_q <= 1'b1;
          o_addr_q       <= pix_addr;
          data_out_q     <= result_c;
          if (x == X_LAST) begin
            x        <= '0;
            y        <= y + YW'(2);
            pix_addr <= pix_addr + ADDR_W'(IMG_W + 1);
            state    <= ((y + YW'(2)) > Y_LAST) ? ST_DONE : ST_CHECK;
          end else begin
            x        <= x + XW'(1);
            pix_addr <= pix_addr + ADDR_W'(1);
            state    <= ST_CHECK;
          end
        end

        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.r_addr       = r_addr_q;
  assign bus.o_addr       = o_addr_q;
  assign bus.data_out     = data_out_q;
  assign bus.output_valid = output_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ela_deinterlacer.sv
// Directed bench for ela_deinterlacer at 4x4, 4-bit x 3 channels.
module tb_ela_deinterlacer;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 12;

  logic clk_p = 1'b0;
  logic rst   = 1'b1;

  always #5 clk_p = ~clk_p;

  ela_deinterlacer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  ela_deinterlacer #(
    .IMG_W(4), .IMG_H(4), .PIX_W(4), .CH(3), .FALLBACK_TH(8)
  ) dut (
    .clk_p(clk_p),
    .rst  (rst),
    .bus  (bus_if)
  );

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] out_mem [16];
  logic [DW-1:0] exp_mem [16];
  int            strobes;
  int            checks   = 0;
  int            failures = 0;
  logic          busy_after_start;

  // Source RAM with one cycle of read latency
  always @(posedge clk_p) bus_if.rd_data <= mem[bus_if.r_addr];

  // Write-side capture
  always @(negedge clk_p) begin
    if (bus_if.output_valid) begin
      out_mem[bus_if.o_addr] = bus_if.data_out;
      strobes++;
    end
  end

  task automatic clear_out();
    strobes = 0;
    for (int i = 0; i < 16; i++) out_mem[i] = 'x;
  endtask

  // Launch a job and wait (bounded) for done; optionally poke start mid-run
  task automatic run_cmd(input logic [1:0] c, input bit inject, output bit timed_out);
    clear_out();
    @(negedge clk_p);
    bus_if.start = 1'b1;
    bus_if.cmd   = c;
    @(negedge clk_p);
    bus_if.start = 1'b0;
    bus_if.cmd   = 2'd0;
    busy_after_start = bus_if.busy;
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_p);
      if (inject && i == 10) begin
        bus_if.start = 1'b1;
        bus_if.cmd   = 2'd0;
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.done) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk_p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.cmd   = 2'd0;
    repeat (3) @(negedge clk_p);
    checks++;
    if (bus_if.output_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl valid=%b busy=%b done=%b want 0 0 0",
               bus_if.output_valid, bus_if.busy, bus_if.done);
    end
    checks++;
    if (bus_if.r_addr !== 4'h0 || bus_if.o_addr !== 4'h0 || bus_if.data_out !== 12'h000) begin
      failures++;
      $display("FAIL reset_bus r_addr=%h o_addr=%h data_out=%h want 0 0 000",
               bus_if.r_addr, bus_if.o_addr, bus_if.data_out);
    end
    rst = 1'b0;
    @(negedge clk_p);
  endtask

  task automatic check_image(input string name, input int want_strobes, input bit timed_out);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s_timeout done never rose", name);
    end
    checks++;
    if (strobes != want_strobes) begin
      failures++;
      $display("FAIL %s_strobes got %0d want %0d", name, strobes, want_strobes);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_mem[i] !== exp_mem[i]) begin
        failures++;
        $display("FAIL %s_pix[%0d] got %h want %h", name, i, out_mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_status done=%b busy=%b want 1 0", name, bus_if.done, bus_if.busy);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 12'((i * 37 + 5) * 13);
      exp_mem[i] = mem[i];
    end
  endtask

  task automatic test_copy();
    bit to;
    load_ramp();
    run_cmd(2'd0, 1'b0, to);
    checks++;
    if (busy_after_start !== 1'b1) begin
      failures++;
      $display("FAIL copy_busy got %b want 1", busy_after_start);
    end
    check_image("copy", 16, to);
  endtask

  // Flat rows: every direction ties, vertical average wins; also pokes start mid-run
  task automatic test_ela_flat();
    bit to;
    mem = '{12'h000, 12'h000, 12'h000, 12'h000,
            12'h123, 12'h123, 12'h123, 12'h123,
            12'h888, 12'h888, 12'h888, 12'h888,
            12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5};
    exp_mem = '{12'h000, 12'h000, 12'h000, 12'h000,
                12'h444, 12'h444, 12'h444, 12'h444,
                12'h888, 12'h888, 12'h888, 12'h888,
                12'h888, 12'h888, 12'h888, 12'h888};
    run_cmd(2'd1, 1'b1, to);
    check_image("ela_flat", 24, to);
  endtask

  task automatic test_ela_diag();
    bit to;
    mem = '{12'h333, 12'hFFF, 12'hF00, 12'h000,
            12'hABC, 12'hABC, 12'hABC, 12'hABC,
            12'h000, 12'h000, 12'h333, 12'h000,
            12'h777, 12'h777, 12'h777, 12'h777};
    // (0,1) edge avg(333,000); (1,1) a-f diagonal; (2,1) c-d diagonal; (3,1) edge
    exp_mem = '{12'h333, 12'hFFF, 12'hF00, 12'h000,
                12'h111, 12'h333, 12'h000, 12'h000,
                12'h000, 12'h000, 12'h333, 12'h000,
                12'h000, 12'h000, 12'h333, 12'h000};
    run_cmd(2'd1, 1'b0, to);
    check_image("ela_diag", 24, to);
  endtask

  // (1,1): D1=12, D2=45, D3=24 -> direction a-f, but all exceed 8
  task automatic test_fallback();
    bit to;
    mem = '{12'h000, 12'hFFF, 12'h000, 12'h000,
            12'h999, 12'h999, 12'h999, 12'h999,
            12'h888, 12'h000, 12'h444, 12'h000,
            12'h111, 12'h111, 12'h111, 12'h111};
    exp_mem = '{12'h000, 12'hFFF, 12'h000, 12'h000,
                12'h444, 12'h222, 12'h000, 12'h000,
                12'h888, 12'h000, 12'h444, 12'h000,
                12'h888, 12'h000, 12'h444, 12'h000};
`ifdef ELA_FALLBACK_EN
    exp_mem[5] = 12'h777;
`endif
    run_cmd(2'd1, 1'b0, to);
    check_image("ela_fallback", 24, to);
  endtask

  task automatic load_rows();
    mem = '{12'h135, 12'h135, 12'h135, 12'h135,
            12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE,
            12'h8A3, 12'h8A3, 12'h8A3, 12'h8A3,
            12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
  endtask

  task automatic test_repeat();
    bit to;
    load_rows();
    exp_mem = '{12'h135, 12'h135, 12'h135, 12'h135,
                12'h135, 12'h135, 12'h135, 12'h135,
                12'h8A3, 12'h8A3, 12'h8A3, 12'h8A3,
                12'h8A3, 12'h8A3, 12'h8A3, 12'h8A3};
    run_cmd(2'd2, 1'b0, to);
    check_image("repeat", 24, to);
  endtask

  task automatic test_vavg();
    bit to;
    load_rows();
    exp_mem = '{12'h135, 12'h135, 12'h135, 12'h135,
                12'h464, 12'h464, 12'h464, 12'h464,
                12'h8A3, 12'h8A3, 12'h8A3, 12'h8A3,
                12'h8A3, 12'h8A3, 12'h8A3, 12'h8A3};
    run_cmd(2'd3, 1'b0, to);
    check_image("vavg", 24, to);
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    load_ramp();
    clear_out();
    @(negedge clk_p);
    bus_if.start = 1'b1;
    bus_if.cmd   = 2'd1;
    @(negedge clk_p);
    bus_if.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_p);
      if (strobes >= 16) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midrst_copy got %0d strobes want 16", strobes);
    end
    repeat (2) @(negedge clk_p);
    rst = 1'b1;
    @(negedge clk_p);
    checks++;
    if (bus_if.output_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 ||
        bus_if.r_addr !== 4'h0 || bus_if.o_addr !== 4'h0 || bus_if.data_out !== 12'h000) begin
      failures++;
      $display("FAIL midrst_outputs valid=%b busy=%b done=%b r=%h o=%h d=%h want all 0",
               bus_if.output_valid, bus_if.busy, bus_if.done,
               bus_if.r_addr, bus_if.o_addr, bus_if.data_out);
    end
    rst = 1'b0;
    @(negedge clk_p);
    run_cmd(2'd0, 1'b0, to);
    check_image("midrst_copy", 16, to);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.cmd   = 2'd0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_copy();
    test_ela_flat();
    test_ela_diag();
    test_fallback();
    test_repeat();
    test_vavg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
